// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU encodings: OP codes, ALUOP classes, FUNCT codes and
//               forwarding selects used by decode, ID/EX and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_ILL = 4'b1111;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [1:0] FWD_RD   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_RD_2 = 2'b11;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// ============================================================================
// Module      : id_ex_stage_if
// Description : Bundle between decode, the ID/EX register and the ALU.
//               IDEX_STATS_EN adds the statistics counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
    parameter int W  = 32,
    parameter int FW = 6
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  rd1;
    logic [W-1:0]  rd2;
    logic [W-1:0]  imm;
    logic          alusrc;
    logic [1:0]    aluop;
    logic [FW-1:0] funct;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [W-1:0]  mem_data;
    logic [W-1:0]  wb_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [3:0]    op;
    logic [W-1:0]  rt_data;
    logic          illegal;
`ifdef IDEX_STATS_EN
    logic [31:0]   xfer_cnt;
    logic [31:0]   stall_cnt;
    logic [15:0]   flush_cnt;

    modport master (
        output in_valid, rd1, rd2, imm, alusrc, aluop, funct, fwd_a, fwd_b,
               mem_data, wb_data, flush, out_ready,
        input  in_ready, out_valid, a, b, op, rt_data, illegal,
               xfer_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, rd1, rd2, imm, alusrc, aluop, funct, fwd_a, fwd_b,
               mem_data, wb_data, flush, out_ready,
        output in_ready, out_valid, a, b, op, rt_data, illegal,
               xfer_cnt, stall_cnt, flush_cnt
    );
`else
    modport master (
        output in_valid, rd1, rd2, imm, alusrc, aluop, funct, fwd_a, fwd_b,
               mem_data, wb_data, flush, out_ready,
        input  in_ready, out_valid, a, b, op, rt_data, illegal
    );

    modport slave (
        input  in_valid, rd1, rd2, imm, alusrc, aluop, funct, fwd_a, fwd_b,
               mem_data, wb_data, flush, out_ready,
        output in_ready, out_valid, a, b, op, rt_data, illegal
    );
`endif

endinterface : id_ex_stage_if

`default_nettype wire

// File: rtl/alu_control.sv
// ============================================================================
// Module      : alu_control
// Description : Combinational ALUOP/FUNCT to ALU operation decoder; flags
//               undecodable R-type FUNCT values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control
    import alu_pkg::*;
#(
    parameter int FW = 6
) (
    input  wire logic [1:0]    i_aluop,
    input  wire logic [FW-1:0] i_funct,
    output logic      [3:0]    o_op,
    output logic               o_illegal
);

    always_comb begin
        o_op      = OP_ILL;
        o_illegal = 1'b0;
        case (i_aluop)
            ALUOP_LDST: o_op = OP_ADD;
            ALUOP_BR:   o_op = OP_SUB;
            ALUOP_ORI:  o_op = OP_OR;
            default: begin
                case (i_funct)
                    FW'(FN_ADD): o_op = OP_ADD;
                    FW'(FN_SUB): o_op = OP_SUB;
                    FW'(FN_AND): o_op = OP_AND;
                    FW'(FN_OR):  o_op = OP_OR;
                    FW'(FN_SLT): o_op = OP_SLT;
                    FW'(FN_NOR): o_op = OP_NOR;
                    default: begin
                        // OP_ILL makes the ALU produce zero for junk encodings
                        o_op      = OP_ILL;
                        o_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule : alu_control

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with operand forwarding, immediate
//               select, ALU decode and valid/ready handshake with flush.
//               Optional statistics counters under IDEX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage
    import alu_pkg::*;
#(
    parameter int W  = 32,
    parameter int FW = 6
) (
    input  wire logic    clk,
    input  wire logic    rst,
    id_ex_stage_if.slave bus
);

    logic         r_valid;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [3:0]   r_op;
    logic [W-1:0] r_rt;
    logic         r_illegal;

    logic         w_in_ready;
    logic         w_capture;
    logic [W-1:0] w_fwd_a;
    logic [W-1:0] w_fwd_b;
    logic [3:0]   w_op;
    logic         w_illegal;

    assign w_in_ready = ~r_valid | bus.out_ready;
    assign w_capture  = bus.in_valid & w_in_ready & ~bus.flush;

    always_comb begin
        w_fwd_a = bus.rd1;
        case (bus.fwd_a)
            FWD_WB:  w_fwd_a = bus.wb_data;
            FWD_MEM: w_fwd_a = bus.mem_data;
            default: w_fwd_a = bus.rd1;
        endcase
    end

    always_comb begin
        w_fwd_b = bus.rd2;
        case (bus.fwd_b)
            FWD_WB:  w_fwd_b = bus.wb_data;
            FWD_MEM: w_fwd_b = bus.mem_data;
            default: w_fwd_b = bus.rd2;
        endcase
    end

    alu_control #(
        .FW (FW)
    ) u_alu_control (
        .i_aluop   (bus.aluop),
        .i_funct   (bus.funct),
        .o_op      (w_op),
        .o_illegal (w_illegal)
    );

    // Flush wins over capture and drain alike
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Operands are frozen at capture; forwarding is not re-sampled in a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_AND;
            r_rt      <= '0;
            r_illegal <= 1'b0;
        end else if (w_capture) begin
            r_a       <= w_fwd_a;
            r_b       <= bus.alusrc ? bus.imm : w_fwd_b;
            r_op      <= w_op;
            r_rt      <= w_fwd_b;
            r_illegal <= w_illegal;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.op        = r_op;
    assign bus.rt_data   = r_rt;
    assign bus.illegal   = r_illegal;

`ifdef IDEX_STATS_EN
    logic [31:0] r_xfer_cnt;
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_xfer_cnt <= r_xfer_cnt + 32'd1;
            end
            if (r_valid & ~bus.out_ready) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (bus.flush & r_valid) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.xfer_cnt  = r_xfer_cnt;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`endif

endmodule : id_ex_stage

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage against a cycle-level
//               behavioural model; honours IDEX_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    localparam int W  = 32;
    localparam int FW = 6;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    id_ex_stage_if #(.W(W), .FW(FW)) bus ();

    id_ex_stage #(.W(W), .FW(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the held instruction
    logic         m_valid;
    logic [W-1:0] m_a, m_b, m_rt;
    logic [3:0]   m_op;
    logic         m_ill;
    longint       m_xfer, m_stall, m_flush;
    logic [W-1:0] got_q[$];

    function automatic logic [4:0] ref_decode(input logic [1:0] aluop, input logic [5:0] funct);
        // {illegal, op}
        if (aluop == 2'b00) return {1'b0, 4'b0010};
        if (aluop == 2'b01) return {1'b0, 4'b0110};
        if (aluop == 2'b11) return {1'b0, 4'b0001};
        case (funct)
            6'b100000: return {1'b0, 4'b0010};
            6'b100010: return {1'b0, 4'b0110};
            6'b100100: return {1'b0, 4'b0000};
            6'b100101: return {1'b0, 4'b0001};
            6'b101010: return {1'b0, 4'b0111};
            6'b100111: return {1'b0, 4'b1100};
            default:   return {1'b1, 4'b1111};
        endcase
    endfunction

    function automatic logic [W-1:0] ref_src(input logic [1:0] sel, input logic [W-1:0] rd);
        if (sel == 2'b01) return bus.wb_data;
        if (sel == 2'b10) return bus.mem_data;
        return rd;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_a = '0; m_b = '0; m_rt = '0; m_op = 4'b0000; m_ill = 1'b0;
        m_xfer = 0; m_stall = 0; m_flush = 0;
    endtask

    // One clock: evaluate the model from the current inputs, then advance
    task automatic tick();
        logic         acc;
        logic [4:0]   dec;
        logic [W-1:0] fa, fb;
        acc = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
        dec = ref_decode(bus.aluop, bus.funct);
        fa  = ref_src(bus.fwd_a, bus.rd1);
        fb  = ref_src(bus.fwd_b, bus.rd2);
        if (bus.out_valid && bus.out_ready && !bus.flush) got_q.push_back(bus.a);
        if (acc) m_xfer = (m_xfer + 1) % (64'd1 << 32);
        if (m_valid && !bus.out_ready) m_stall = (m_stall + 1) % (64'd1 << 32);
        if (bus.flush && m_valid) m_flush = (m_flush + 1) % (64'd1 << 16);
        @(posedge clk);
        #1;
        if (bus.flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_a = fa; m_rt = fb; m_b = bus.alusrc ? bus.imm : fb;
            m_op = dec[3:0]; m_ill = dec[4];
        end else if (bus.out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive_instr(input logic [W-1:0] rd1, input logic [W-1:0] rd2,
                               input logic [1:0] aluop, input logic [5:0] funct);
        bus.in_valid = 1'b1; bus.rd1 = rd1; bus.rd2 = rd2; bus.aluop = aluop;
        bus.funct = funct; bus.alusrc = 1'b0; bus.fwd_a = 2'b00; bus.fwd_b = 2'b00;
        bus.imm = '0; bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.a !== '0 || bus.b !== '0 || bus.op !== 4'b0000 ||
            bus.rt_data !== '0 || bus.illegal !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b a=%h b=%h op=%b rt=%h ill=%b rdy=%b, want all zero, rdy=1",
                     bus.out_valid, bus.a, bus.b, bus.op, bus.rt_data, bus.illegal, bus.in_ready);
        end
`ifdef IDEX_STATS_EN
        n_tests++;
        if (bus.xfer_cnt !== 0 || bus.stall_cnt !== 0 || bus.flush_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_counters: xfer=%0d stall=%0d flush=%0d, want 0",
                     bus.xfer_cnt, bus.stall_cnt, bus.flush_cnt);
        end
`endif
    endtask

    task automatic test_rtype();
        drive_instr(32'd5, 32'd3, 2'b10, 6'b101010);
        bus.out_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.a !== 32'd5 || bus.b !== 32'd3 || bus.op !== 4'b0111) begin
            n_fail++;
            $display("FAIL rtype_slt: valid=%b a=%0d b=%0d op=%b, want 1 5 3 0111",
                     bus.out_valid, bus.a, bus.b, bus.op);
        end
        bus.funct = 6'b100111;
        tick();
        n_tests++;
        if (bus.op !== 4'b1100 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL rtype_nor: op=%b ill=%b, want 1100 0", bus.op, bus.illegal);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_fwd_imm();
        drive_instr(32'hDEAD0001, 32'h0000BEEF, 2'b00, 6'b000000);
        bus.fwd_a = 2'b10; bus.mem_data = 32'h1234; bus.wb_data = 32'h5555;
        bus.alusrc = 1'b1; bus.imm = 32'hFFFFFFFC;
        tick();
        n_tests++;
        if (bus.a !== 32'h1234 || bus.b !== 32'hFFFFFFFC || bus.op !== 4'b0010 ||
            bus.rt_data !== 32'h0000BEEF) begin
            n_fail++;
            $display("FAIL fwd_imm: a=%h b=%h op=%b rt=%h, want 1234 fffffffc 0010 0000beef",
                     bus.a, bus.b, bus.op, bus.rt_data);
        end
        bus.fwd_a = 2'b01; bus.fwd_b = 2'b10; bus.alusrc = 1'b0;
        tick();
        n_tests++;
        if (bus.a !== 32'h5555 || bus.b !== 32'h1234 || bus.rt_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL fwd_wb_mem: a=%h b=%h rt=%h, want 5555 1234 1234",
                     bus.a, bus.b, bus.rt_data);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        got_q.delete();
        exp_q = '{32'd10, 32'd11, 32'd12};
        drive_instr(32'd10, 32'd0, 2'b00, 6'b0);
        bus.out_ready = 1'b1;
        tick();
        drive_instr(32'd11, 32'd0, 2'b00, 6'b0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests++;
            if (bus.in_ready !== 1'b0 || bus.a !== 32'd10 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: rdy=%b a=%0d valid=%b, want 0 10 1",
                         i, bus.in_ready, bus.a, bus.out_valid);
            end
            bus.rd1 = 32'd99 + i;
            tick();
            bus.rd1 = 32'd11;
        end
        bus.out_ready = 1'b1;
        tick();
        drive_instr(32'd12, 32'd0, 2'b00, 6'b0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_tests++;
        if (got_q != exp_q || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_order: got %p valid=%b, want %p valid=0",
                     got_q, bus.out_valid, exp_q);
        end
    endtask

    task automatic test_flush();
        longint f0;
        drive_instr(32'h77, 32'h1, 2'b01, 6'b0);
        bus.out_ready = 1'b0;
        tick();
        f0 = m_flush;
        drive_instr(32'h88, 32'h2, 2'b00, 6'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.a !== 32'h77 || bus.op !== 4'b0110) begin
            n_fail++;
            $display("FAIL flush_prio: valid=%b a=%h op=%b, want 0 77 0110",
                     bus.out_valid, bus.a, bus.op);
        end
`ifdef IDEX_STATS_EN
        n_tests++;
        if (bus.flush_cnt !== 16'(f0 + 1)) begin
            n_fail++;
            $display("FAIL flush_cnt: got %0d want %0d", bus.flush_cnt, f0 + 1);
        end
`endif
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_illegal();
        drive_instr(32'h1, 32'h2, 2'b10, 6'b000000);
        tick();
        n_tests++;
        if (bus.op !== 4'b1111 || bus.illegal !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_funct: op=%b ill=%b valid=%b, want 1111 1 1",
                     bus.op, bus.illegal, bus.out_valid);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive_instr(32'hABCD, 32'h1234, 2'b10, 6'b100000);
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.a !== '0 || bus.b !== '0 || bus.op !== 4'b0000 ||
            bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_stall: valid=%b a=%h b=%h op=%b rdy=%b, want 0 0 0 0000 1",
                     bus.out_valid, bus.a, bus.b, bus.op, bus.in_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [5:0] fn_pool[7];
        fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.rd1 = $urandom; bus.rd2 = $urandom; bus.imm = $urandom;
            bus.mem_data = $urandom; bus.wb_data = $urandom;
            bus.alusrc = 1'($urandom); bus.aluop = 2'($urandom);
            bus.fwd_a = 2'($urandom); bus.fwd_b = 2'($urandom);
            bus.funct = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 6)];
            #1;
            n_tests++;
            if (bus.in_ready !== (!m_valid || bus.out_ready)) begin
                n_fail++;
                $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, bus.in_ready,
                         (!m_valid || bus.out_ready));
            end
            tick();
            n_tests++;
            if (bus.out_valid !== m_valid || bus.a !== m_a || bus.b !== m_b ||
                bus.op !== m_op || bus.rt_data !== m_rt || bus.illegal !== m_ill) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: got v=%b a=%h b=%h op=%b rt=%h il=%b want v=%b a=%h b=%h op=%b rt=%h il=%b",
                         i, bus.out_valid, bus.a, bus.b, bus.op, bus.rt_data, bus.illegal,
                         m_valid, m_a, m_b, m_op, m_rt, m_ill);
            end
        end
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
`ifdef IDEX_STATS_EN
        n_tests++;
        if (bus.xfer_cnt !== 32'(m_xfer) || bus.stall_cnt !== 32'(m_stall) ||
            bus.flush_cnt !== 16'(m_flush)) begin
            n_fail++;
            $display("FAIL rnd_counters: got x=%0d s=%0d f=%0d want x=%0d s=%0d f=%0d",
                     bus.xfer_cnt, bus.stall_cnt, bus.flush_cnt, m_xfer, m_stall, m_flush);
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        bus.rd1 = '0; bus.rd2 = '0; bus.imm = '0; bus.alusrc = 1'b0;
        bus.aluop = 2'b00; bus.funct = '0; bus.fwd_a = 2'b00; bus.fwd_b = 2'b00;
        bus.mem_data = '0; bus.wb_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_rtype();
        test_fwd_imm();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule : tb_id_ex_stage

`default_nettype wire
